// File: rtl/kakacpu_pkg.sv
// Shared types and default widths for the memory arbiter and its helpers.
package kakacpu_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 3;

    // Who owns the memory response arriving in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    // Map this cycle's (mutually exclusive) grants onto the owner encoding.
    function automatic owner_t grant_owner(input logic if_gnt, input logic d_gnt);
        owner_t own;
        own = OWN_NONE;
        if (if_gnt) begin
            own = OWN_IF;
        end else if (d_gnt) begin
            own = OWN_D;
        end
        return own;
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive data grants taken while a fetch is waiting and flags
// when the fetch side must be given the memory on the next arbitration.
module arb_starve_ctr
    import kakacpu_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_gnt,
    input  logic d_gnt,
    output logic starve_hit
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_p1;

    // Saturating count of data wins over a pending fetch; any fetch win or an idle fetch side clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_p1 <= '0;
        end else if (!if_req || if_gnt) begin
            cnt_p1 <= '0;
        end else if (d_gnt && (cnt_p1 != CNT_MAX)) begin
            cnt_p1 <= cnt_p1 + CNT_W'(1);
        end
    end

    assign starve_hit = (cnt_p1 == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory (1-cycle read latency) between
// the instruction-fetch and data requesters. Data has priority unless the
// fetch side has been starved for STARVE_MAX consecutive data grants.
module mem_arbiter
    import kakacpu_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    input  logic              if_kill,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic   starve_hit;
    logic   if_win;
    logic   d_win;
    owner_t owner_p1;
    logic   kill_p1;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_gnt     (if_win),
        .d_gnt      (d_win),
        .starve_hit (starve_hit)
    );

    // ---- stage p0: arbitration and request mux ----

    // Combinational grant: data first, fetch only when idle data side or starved; masked in reset.
    always_comb begin
        if_win = 1'b0;
        d_win  = 1'b0;
        if (rst) begin
            if (if_req && (!d_req || starve_hit)) begin
                if_win = 1'b1;
            end else if (d_req) begin
                d_win = 1'b1;
            end
        end
    end

    assign if_gnt = if_win;
    assign d_gnt  = d_win;

    // Steer the winner onto the memory port; fetches are always reads, idle port is all-zero.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_win) begin
            mem_addr = if_addr;
        end else if (d_win) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    // ---- stage p1: response ownership (memory data arrives one cycle after grant) ----

    // Remember who owns next cycle's response and whether that fetch was killed as it was granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_p1 <= OWN_NONE;
            kill_p1  <= 1'b0;
        end else begin
            owner_p1 <= grant_owner(if_win, d_win);
            kill_p1  <= if_kill && if_win;
        end
    end

    // Route memory read data to the owner; a kill now or at grant time drops a fetch response.
    always_comb begin
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        if (rst) begin
            case (owner_p1)
                OWN_IF: begin
                    if (!kill_p1 && !if_kill) begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end
                end
                OWN_D: begin
                    d_rvalid = 1'b1;
                    d_rdata  = mem_rdata;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter plus a mid-flight reset sequence.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_kill;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic prev_ig = 1'b0;
    logic prev_dg = 1'b0;
    logic prev_k  = 1'b0;

    mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_kill   (if_kill),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in_b  = {rst, if_req, if_kill, d_req, d_we}
    // exp_b = {if_gnt, d_gnt, mem_we, if_rvalid, d_rvalid, d_rdata_dont_care}
    typedef struct {
        string       name;
        logic [4:0]  in_b;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [31:0] mrd;
        logic [5:0]  exp_b;
        logic [31:0] ema;
        logic [31:0] emw;
        logic [31:0] eird;
        logic [31:0] edrd;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string nm, input logic [4:0] in_b, input logic [31:0] ia,
                       input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] mrd,
                       input logic [5:0] exp_b, input logic [31:0] ema, input logic [31:0] emw,
                       input logic [31:0] eird, input logic [31:0] edrd);
        vec_t v;
        v.name = nm; v.in_b = in_b; v.ia = ia; v.da = da; v.dwd = dwd; v.mrd = mrd;
        v.exp_b = exp_b; v.ema = ema; v.emw = emw; v.eird = eird; v.edrd = edrd;
        vq.push_back(v);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Per-cycle properties, sampled just before the rising edge.
    task automatic inv(input string tag);
        logic e_iv;
        logic e_dv;
        chk1({tag, ".one_grant"}, if_gnt & d_gnt, 1'b0);
        chk1({tag, ".we_only_dgnt"}, mem_we & ~d_gnt, 1'b0);
        e_iv = prev_ig & ~prev_k & ~if_kill & rst;
        e_dv = prev_dg & rst;
        chk1({tag, ".rsp_if_once"}, if_rvalid, e_iv);
        chk1({tag, ".rsp_d_once"}, d_rvalid, e_dv);
        prev_ig = if_gnt;
        prev_dg = d_gnt;
        prev_k  = if_kill;
    endtask

    task automatic drive_idle();
        if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive_idle();
        mem_rdata = '0;

        //   name            rst/ir/ik/dr/we  ia         da         dwd           mrd           ig/dg/we/iv/dv/dc ema        emw           eird          edrd
        add("rst_mask",     5'b01011, 32'h10,  32'h20, 32'h5,        32'hAAAA,     6'b000000, 32'h0,   32'h0,        32'h0,        32'h0);
        add("rst_idle",     5'b00000, 32'h0,   32'h0,  32'h0,        32'hBBBB,     6'b000000, 32'h0,   32'h0,        32'h0,        32'h0);
        add("fetch_gnt",    5'b11000, 32'h10,  32'h0,  32'h0,        32'h1111,     6'b100000, 32'h10,  32'h0,        32'h0,        32'h0);
        add("fetch_rsp",    5'b10000, 32'h0,   32'h0,  32'h0,        32'h12345678, 6'b000100, 32'h0,   32'h0,        32'h12345678, 32'h0);
        add("idle",         5'b10000, 32'h0,   32'h0,  32'h0,        32'h55,       6'b000000, 32'h0,   32'h0,        32'h0,        32'h0);
        add("store",        5'b10011, 32'h0,   32'h20, 32'hDEADBEEF, 32'h99,       6'b011000, 32'h20,  32'hDEADBEEF, 32'h0,        32'h0);
        add("store_ack",    5'b10000, 32'h0,   32'h0,  32'h0,        32'h77,       6'b000011, 32'h0,   32'h0,        32'h0,        32'h0);
        add("load_gnt",     5'b10010, 32'h0,   32'h40, 32'h0,        32'h0,        6'b010000, 32'h40,  32'h0,        32'h0,        32'h0);
        add("load_rsp_bb",  5'b11000, 32'h80,  32'h0,  32'h0,        32'hCAFE0001, 6'b100010, 32'h80,  32'h0,        32'h0,        32'hCAFE0001);
        add("fetch_rsp_bb", 5'b10010, 32'h0,   32'h44, 32'h0,        32'hBEEF0002, 6'b010100, 32'h44,  32'h0,        32'hBEEF0002, 32'h0);
        add("load_rsp2",    5'b10000, 32'h0,   32'h0,  32'h0,        32'h3,        6'b000010, 32'h0,   32'h0,        32'h0,        32'h3);
        add("kill_same",    5'b11100, 32'h100, 32'h0,  32'h0,        32'h0,        6'b100000, 32'h100, 32'h0,        32'h0,        32'h0);
        add("kill_rsp",     5'b10010, 32'h0,   32'h48, 32'h0,        32'h4,        6'b010000, 32'h48,  32'h0,        32'h0,        32'h0);
        add("kill_d_rsp",   5'b10000, 32'h0,   32'h0,  32'h0,        32'h5,        6'b000010, 32'h0,   32'h0,        32'h0,        32'h5);
        add("fetch_b",      5'b11000, 32'h104, 32'h0,  32'h0,        32'h0,        6'b100000, 32'h104, 32'h0,        32'h0,        32'h0);
        add("kill_late",    5'b11100, 32'h108, 32'h0,  32'h0,        32'h6,        6'b100000, 32'h108, 32'h0,        32'h0,        32'h0);
        add("kill_new",     5'b10000, 32'h0,   32'h0,  32'h0,        32'h7,        6'b000000, 32'h0,   32'h0,        32'h0,        32'h0);
        add("load_c",       5'b10010, 32'h0,   32'h4C, 32'h0,        32'h0,        6'b010000, 32'h4C,  32'h0,        32'h0,        32'h0);
        add("kill_dpass",   5'b10100, 32'h0,   32'h0,  32'h0,        32'h8,        6'b000010, 32'h0,   32'h0,        32'h0,        32'h8);
        add("cont1",        5'b11010, 32'h200, 32'h40, 32'h0,        32'h0,        6'b010000, 32'h40,  32'h0,        32'h0,        32'h0);
        add("cont2",        5'b11010, 32'h200, 32'h40, 32'h0,        32'h21,       6'b010010, 32'h40,  32'h0,        32'h0,        32'h21);
        add("cont3",        5'b11010, 32'h200, 32'h40, 32'h0,        32'h22,       6'b010010, 32'h40,  32'h0,        32'h0,        32'h22);
        add("cont4",        5'b11010, 32'h200, 32'h40, 32'h0,        32'h23,       6'b100010, 32'h200, 32'h0,        32'h0,        32'h23);
        add("cont5",        5'b11010, 32'h200, 32'h40, 32'h0,        32'h24,       6'b010100, 32'h40,  32'h0,        32'h24,       32'h0);
        add("cont6",        5'b10000, 32'h0,   32'h0,  32'h0,        32'h25,       6'b000010, 32'h0,   32'h0,        32'h0,        32'h25);
        add("stv1",         5'b11010, 32'h300, 32'h40, 32'h0,        32'h0,        6'b010000, 32'h40,  32'h0,        32'h0,        32'h0);
        add("stv2",         5'b11010, 32'h300, 32'h40, 32'h0,        32'h31,       6'b010010, 32'h40,  32'h0,        32'h0,        32'h31);
        add("stv3_clear",   5'b10010, 32'h0,   32'h40, 32'h0,        32'h32,       6'b010010, 32'h40,  32'h0,        32'h0,        32'h32);
        add("stv4",         5'b11010, 32'h300, 32'h40, 32'h0,        32'h33,       6'b010010, 32'h40,  32'h0,        32'h0,        32'h33);
        add("stv5",         5'b11010, 32'h300, 32'h40, 32'h0,        32'h34,       6'b010010, 32'h40,  32'h0,        32'h0,        32'h34);
        add("stv6",         5'b11010, 32'h300, 32'h40, 32'h0,        32'h35,       6'b010010, 32'h40,  32'h0,        32'h0,        32'h35);
        add("stv7",         5'b11010, 32'h300, 32'h40, 32'h0,        32'h36,       6'b100010, 32'h300, 32'h0,        32'h0,        32'h36);
        add("stv8",         5'b10000, 32'h0,   32'h0,  32'h0,        32'h37,       6'b000100, 32'h0,   32'h0,        32'h37,       32'h0);

        foreach (vq[i]) begin
            @(negedge clk);
            rst       = vq[i].in_b[4];
            if_req    = vq[i].in_b[3];
            if_kill   = vq[i].in_b[2];
            d_req     = vq[i].in_b[1];
            d_we      = vq[i].in_b[0];
            if_addr   = vq[i].ia;
            d_addr    = vq[i].da;
            d_wdata   = vq[i].dwd;
            mem_rdata = vq[i].mrd;
            #2;
            chk1 ({vq[i].name, ".if_gnt"},    if_gnt,    vq[i].exp_b[5]);
            chk1 ({vq[i].name, ".d_gnt"},     d_gnt,     vq[i].exp_b[4]);
            chk1 ({vq[i].name, ".mem_we"},    mem_we,    vq[i].exp_b[3]);
            chk32({vq[i].name, ".mem_addr"},  mem_addr,  vq[i].ema);
            chk32({vq[i].name, ".mem_wdata"}, mem_wdata, vq[i].emw);
            chk1 ({vq[i].name, ".if_rvalid"}, if_rvalid, vq[i].exp_b[2]);
            chk32({vq[i].name, ".if_rdata"},  if_rdata,  vq[i].eird);
            chk1 ({vq[i].name, ".d_rvalid"},  d_rvalid,  vq[i].exp_b[1]);
            if (!vq[i].exp_b[0]) begin
                chk32({vq[i].name, ".d_rdata"}, d_rdata, vq[i].edrd);
            end
            #2;
            inv(vq[i].name);
        end

        // Reset asserted between a fetch grant and its response.
        @(negedge clk);
        drive_idle();
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h400; mem_rdata = 32'h0;
        #2;
        chk1 ("rmf.grant",    if_gnt,   1'b1);
        chk32("rmf.addr",     mem_addr, 32'h400);
        #2;
        inv("rmf.grant");
        @(posedge clk);
        #2;
        rst = 1'b0; mem_rdata = 32'hF00D;
        #1;
        chk1 ("rmf.low.if_gnt",    if_gnt,    1'b0);
        chk1 ("rmf.low.d_gnt",     d_gnt,     1'b0);
        chk1 ("rmf.low.if_rvalid", if_rvalid, 1'b0);
        chk32("rmf.low.if_rdata",  if_rdata,  32'h0);
        chk1 ("rmf.low.d_rvalid",  d_rvalid,  1'b0);
        chk32("rmf.low.mem_addr",  mem_addr,  32'h0);
        chk1 ("rmf.low.mem_we",    mem_we,    1'b0);
        @(negedge clk);
        #4;
        inv("rmf.low");
        @(negedge clk);
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h404;
        #2;
        chk1 ("rmf.rel.no_rvalid", if_rvalid, 1'b0);
        chk1 ("rmf.rel.if_gnt",    if_gnt,    1'b1);
        chk32("rmf.rel.mem_addr",  mem_addr,  32'h404);
        #2;
        inv("rmf.rel");
        @(negedge clk);
        drive_idle();
        mem_rdata = 32'h600D;
        #2;
        chk1 ("rmf.rsp.if_rvalid", if_rvalid, 1'b1);
        chk32("rmf.rsp.if_rdata",  if_rdata,  32'h600D);
        #2;
        inv("rmf.rsp");
        @(negedge clk);
        mem_rdata = 32'h1234;
        #2;
        chk1 ("rmf.end.if_rvalid", if_rvalid, 1'b0);
        chk32("rmf.end.if_rdata",  if_rdata,  32'h0);
        #2;
        inv("rmf.end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width; STARVE_MAX, default 3, maximum consecutive data grants while a fetch waits.
REQ-002 One clock, clk; reset rst, asynchronous, active-low; all state SHALL be clocked on posedge clk.
REQ-003 Ports SHALL be, in this order (name direction width meaning):
  clk in 1 clock; rst in 1 async active-low reset;
  if_req in 1 fetch request; if_addr in ADDR_W fetch address; if_gnt out 1 fetch granted this cycle;
  if_kill in 1 discard in-flight fetch response (branch/flush);
  if_rvalid out 1 fetch data valid; if_rdata out DATA_W fetch data;
  d_req in 1 data request; d_we in 1 write enable; d_addr in ADDR_W data address; d_wdata in DATA_W write data;
  d_gnt out 1 data granted this cycle; d_rvalid out 1 data response (read data or write ack); d_rdata out DATA_W load data;
  mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W (synchronous memory, 1-cycle read latency).

Function
REQ-004 The block SHALL share one single-port synchronous memory between the fetch and data requesters, arbitrating every cycle.
REQ-005 Grant SHALL be combinational from the requests and the starvation count; at most one of if_gnt/d_gnt SHALL be high per cycle.
REQ-006 Priority: data over fetch, except when starve_cnt == STARVE_MAX and if_req is high, in which case fetch SHALL win.
REQ-007 starve_cnt SHALL increment (saturating at STARVE_MAX) on a d_gnt while if_req is high, and clear on any if_gnt or when if_req is low.
REQ-008 In a granted cycle, mem_addr/mem_we/mem_wdata SHALL carry the winner's addr/we/wdata; with no grant: mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-009 mem_we SHALL be high only for a data grant with d_we = 1; fetch accesses SHALL always be reads.
REQ-010 A registered owner field (NONE/IF/D) SHALL record each cycle's grant; the response SHALL appear exactly one cycle after grant.
REQ-011 Owner IF: if_rvalid = 1, if_rdata = mem_rdata; owner D: d_rvalid = 1, d_rdata = mem_rdata (write: d_rvalid pulses as ack, d_rdata don't-care).
REQ-012 if_rdata/d_rdata SHALL be 0 when the matching rvalid is low.
REQ-013 Back-to-back grants SHALL be supported: throughput one access per cycle, response of cycle N overlapping grant of cycle N+1.
REQ-014 if_kill high in cycle N SHALL suppress if_rvalid for a fetch granted in cycle N-1 (response in N) and for a fetch granted in cycle N (response in N+1); data traffic SHALL be unaffected.
REQ-015 if_kill SHALL NOT block a new fetch grant in the same cycle; that fetch's response is killed per REQ-014.
REQ-016 Simultaneous if_req and d_req with starve_cnt < STARVE_MAX: d_gnt = 1, if_gnt = 0; requesters SHALL hold req/addr until granted.

Reset
REQ-017 While rst is low: owner = NONE, starve_cnt = 0, kill flag = 0; all outputs SHALL be 0 (grants masked).
REQ-018 Reset asserted with an access in flight SHALL drop its response; no rvalid pulse SHALL follow deassertion.
REQ-019 First grant SHALL be possible in the first clock edge after rst deasserts.

Structure
REQ-020 Shared package kakacpu_pkg SHALL hold typedef enum owner_t {OWN_NONE, OWN_IF, OWN_D} and the default width constants.
REQ-021 The starvation counter SHALL be a sub-module, arb_starve_ctr (inputs: clk, rst, if_req, if_gnt, d_gnt; output: starve_hit).
REQ-022 All datapath outputs SHALL be driven via muxes on owner/grant; the block SHALL contain no memory array.

Verification
REQ-023 Fetch only: if_req=1, if_addr=0x10 for one cycle -> if_gnt=1, mem_addr=0x10, mem_we=0; next cycle if_rvalid=1, if_rdata=mem_rdata.
REQ-024 Contention: if_req and d_req (read, 0x40) held -> d_gnt on cycles 1-3, if_gnt on cycle 4 (STARVE_MAX=3), d_gnt resumes on cycle 5.
REQ-025 Store: d_req=1, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> mem_we=1 with those values; next cycle d_rvalid=1, if_rvalid=0.
REQ-026 Kill: fetch granted at N, if_kill=1 at N -> no if_rvalid at N+1; a data read granted at N+1 returns d_rvalid at N+2.
REQ-027 Reset mid-flight: grant at N, rst low between N and N+1 -> all outputs 0, no rvalid after release; a fresh if_req is granted on the first edge after release.
REQ-028 Bench SHALL assert: never both grants high, exactly one rvalid per granted unkilled access, mem_we only with d_gnt.
